// File: rtl/posit32_encode_if.sv
`default_nettype none
// ============================================================================
// Module   : posit32_encode_if
// Purpose  : Valid/ready bundle for the posit32 encode pipeline. The producer
//            and result consumer use the master side, the encoder the slave.
// Revision : 1.0 - initial release
// ============================================================================
interface posit32_encode_if;
    logic              in_valid;
    logic              in_ready;
    logic              in_zero;
    logic              in_nar;
    logic              in_sign;
    logic signed [8:0] in_scale;
    logic [27:0]       in_frac;
    logic              in_sticky;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_posit;

    modport master (
        output in_valid, in_zero, in_nar, in_sign, in_scale, in_frac, in_sticky,
        output out_ready,
        input  in_ready, out_valid, out_posit
    );

    modport slave (
        input  in_valid, in_zero, in_nar, in_sign, in_scale, in_frac, in_sticky,
        input  out_ready,
        output in_ready, out_valid, out_posit
    );
endinterface
`default_nettype wire

// File: rtl/posit32_encode_pipe.sv
`default_nettype none
// ============================================================================
// Module   : posit32_encode_pipe
// Purpose  : Packs sign/scale/fraction into a 32-bit posit (es=2) with
//            round-to-nearest-even. Three stages: classify, assemble,
//            round/sign. Whole-pipe stall on output backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module posit32_encode_pipe #(
    parameter int NBITS  = 32,
    parameter int ES     = 2,
    parameter int FRAC_W = 28
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    posit32_encode_if.slave bus
);

    localparam logic signed [8:0] c_SCALE_MAX  = 9'sd120;
    localparam logic signed [8:0] c_SCALE_MIN  = -9'sd120;
    localparam logic [31:0]       c_NAR        = 32'h8000_0000;
    localparam logic [30:0]       c_MAXPOS_MAG = 31'h7FFF_FFFF;
    localparam logic [30:0]       c_MINPOS_MAG = 31'h0000_0001;

    generate
        if (NBITS != 32 || ES != 2 || FRAC_W != 28) begin : g_param_check
            $error("posit32_encode_pipe supports only NBITS=32, ES=2, FRAC_W=28");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic        r_s1_valid;
    logic        r_s1_nar;
    logic        r_s1_zero;
    logic        r_s1_sign;
    logic        r_s1_minpos;
    logic        r_s1_pol;
    logic [4:0]  r_s1_shamt;
    logic [1:0]  r_s1_exp;
    logic [27:0] r_s1_frac;
    logic        r_s1_sticky;

    logic        r_s2_valid;
    logic        r_s2_nar;
    logic        r_s2_zero;
    logic        r_s2_sign;
    logic        r_s2_minpos;
    logic [30:0] r_s2_mag;
    logic        r_s2_guard;
    logic        r_s2_sticky;

    logic        r_out_valid;
    logic [31:0] r_out_posit;

    // The whole pipe moves together; bubbles are kept, so a held result
    // freezes every stage behind it.
    logic w_en;
    assign w_en          = !r_out_valid || bus.out_ready;
    assign bus.in_ready  = w_en;
    assign bus.out_valid = r_out_valid;
    assign bus.out_posit = r_out_posit;

    // ------------------------------------------------------------------
    // S1: classify. The regime is described by its polarity (1 = run of
    // ones, k >= 0) and a shift count: k for k >= 0, -k-1 for k < 0.
    // ------------------------------------------------------------------
    logic signed [8:0] w_scale_sat;
    logic signed [6:0] w_k;
    logic              w_minpos;
    logic              w_pol;
    logic [4:0]        w_shamt;

    // Saturate scale and derive regime polarity and run length.
    always_comb begin
        w_minpos    = (bus.in_scale < c_SCALE_MIN);
        w_scale_sat = (bus.in_scale > c_SCALE_MAX) ? c_SCALE_MAX : bus.in_scale;
        w_k         = w_scale_sat[8:2];
        w_pol       = !w_k[6];
        w_shamt     = 5'(w_k[6] ? ~w_k : w_k);
    end

    // Stage-1 register: capture the classified beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_nar    <= 1'b0;
            r_s1_zero   <= 1'b0;
            r_s1_sign   <= 1'b0;
            r_s1_minpos <= 1'b0;
            r_s1_pol    <= 1'b0;
            r_s1_shamt  <= 5'd0;
            r_s1_exp    <= 2'd0;
            r_s1_frac   <= 28'd0;
            r_s1_sticky <= 1'b0;
        end else if (w_en) begin
            r_s1_valid  <= bus.in_valid;
            r_s1_nar    <= bus.in_nar;
            r_s1_zero   <= bus.in_zero;
            r_s1_sign   <= bus.in_sign;
            r_s1_minpos <= w_minpos;
            r_s1_pol    <= w_pol;
            r_s1_shamt  <= w_shamt;
            r_s1_exp    <= w_scale_sat[1:0];
            r_s1_frac   <= bus.in_frac;
            r_s1_sticky <= bus.in_sticky;
        end
    end

    // ------------------------------------------------------------------
    // S2: assemble. Seed {pol, ~pol, e, frac} at the top of a 64-bit word
    // and shift right arithmetically: the fill replicates pol, which
    // lengthens the regime run to its full size. Bits [63:33] are the
    // magnitude, bit 32 the guard, everything below feeds sticky. Large
    // regimes push e/frac into the dropped part automatically.
    // ------------------------------------------------------------------
    logic [63:0] w_base;
    logic [63:0] w_field;

    // Build the aligned regime/exponent/fraction field.
    always_comb begin
        w_base  = {r_s1_pol, !r_s1_pol, r_s1_exp, r_s1_frac, 32'd0};
        w_field = $signed(w_base) >>> r_s1_shamt;
    end

    // Stage-2 register: magnitude plus rounding information.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid  <= 1'b0;
            r_s2_nar    <= 1'b0;
            r_s2_zero   <= 1'b0;
            r_s2_sign   <= 1'b0;
            r_s2_minpos <= 1'b0;
            r_s2_mag    <= 31'd0;
            r_s2_guard  <= 1'b0;
            r_s2_sticky <= 1'b0;
        end else if (w_en) begin
            r_s2_valid  <= r_s1_valid;
            r_s2_nar    <= r_s1_nar;
            r_s2_zero   <= r_s1_zero;
            r_s2_sign   <= r_s1_sign;
            r_s2_minpos <= r_s1_minpos;
            r_s2_mag    <= w_field[63:33];
            r_s2_guard  <= w_field[32];
            r_s2_sticky <= (|w_field[31:0]) | r_s1_sticky;
        end
    end

    // ------------------------------------------------------------------
    // S3: round to nearest even, clamp into [minpos, maxpos], negate.
    // ------------------------------------------------------------------
    logic        w_round_up;
    logic [31:0] w_sum;
    logic [30:0] w_mag;
    logic [31:0] w_posit;

    // Round, clamp, apply sign and special values.
    always_comb begin
        w_round_up = r_s2_guard && (r_s2_mag[0] || r_s2_sticky);
        w_sum      = {1'b0, r_s2_mag} + {31'd0, w_round_up};
        w_mag      = w_sum[31] ? c_MAXPOS_MAG : w_sum[30:0];
        if (w_mag == 31'd0 || r_s2_minpos) begin
            w_mag = c_MINPOS_MAG;
        end
        w_posit = r_s2_sign ? (32'd0 - {1'b0, w_mag}) : {1'b0, w_mag};
        if (r_s2_nar) begin
            w_posit = c_NAR;
        end else if (r_s2_zero) begin
            w_posit = 32'd0;
        end
    end

    // Output register: holds steady while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_posit <= 32'd0;
        end else if (w_en) begin
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_out_posit <= w_posit;
            end
        end
    end

endmodule
`default_nettype wire
